alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_core.sv | 23 ++
 rtl/alu_muldiv.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state type for the alu_muldiv slice.
package alu_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: AND/OR/ADD/SUB/SLT; any other op yields 0.
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative unsigned multiply (shift-add) and optional restoring divide.
// Define ALU_DIV_EN to build the DIV state and divider datapath.
import alu_pkg::*;

module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    // opnd holds the multiplicand or divisor; {acc_hi,acc_lo} is the shared working pair.
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
    logic [WIDTH-1:0] core_y;
    logic             last;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (core_y)
    );

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_hi, div_lo;

    // acc_hi is the partial remainder; acc_lo shifts dividend bits out and quotient bits in.
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_hi    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo    = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
`endif

    assign last = (count == CW'(WIDTH-1));
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    count <= '0;
                    if (op == OP_MULU) begin
                        state  <= MUL;
                        opnd   <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                    end
`ifdef ALU_DIV_EN
                    else if (op == OP_DIVU && b != '0) begin
                        state  <= DIV;
                        opnd   <= b;
                        acc_hi <= '0;
                        acc_lo <= a;
                    end else if (op == OP_DIVU) begin
                        result      <= '1;
                        result_hi   <= a;
                        zero        <= 1'b0;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
`endif
                    else begin
                        result      <= core_y;
                        result_hi   <= '0;
                        zero        <= (core_y == '0);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    count  <= count + 1'b1;
                    if (last) begin
                        state       <= IDLE;
                        result      <= mul_lo;
                        result_hi   <= mul_hi;
                        zero        <= (mul_lo == '0);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    count  <= count + 1'b1;
                    if (last) begin
                        state       <= IDLE;
                        result      <= div_lo;
                        result_hi   <= div_hi;
                        zero        <= (div_lo == '0);
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
